pipe_hazard_ctrl: RTL and testbench

//   Sequencer for the 5-stage pipeline registers: load PC, hold, or insert a bubble per stage.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC enable, per-stage load/bubble, IF/ID hold and global freeze
// for load-use hazards, taken branches and multi-cycle data-memory accesses.
module pipe_hazard_ctrl #(
  parameter logic [4:0] LOAD_OPC    = 5'b00000,
  parameter logic [4:0] STORE_OPC   = 5'b01000,
  parameter int         MEM_TIMEOUT = 64,
  parameter int         CNT_W       = 16
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       opcode_rg2,
  input  logic [4:0]       rd_rg2,
  input  logic             PCSel,
  input  logic [4:0]       opcode_rg3,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             hold_1,
  output logic             enb_1,
  output logic             enb_2,
  output logic             enb_3,
  output logic             frz,
  output logic             dmem_req,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            mem_op;
  logic            load_use_hit;
  logic            bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_op = (opcode_rg3 == LOAD_OPC) || (opcode_rg3 == STORE_OPC);

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use_hit = (opcode_rg2 == LOAD_OPC) && (rd_rg2 != 5'd0) &&
                        ((rs1_used_id && (rs1_id == rd_rg2)) ||
                         (rs2_used_id && (rs2_id == rd_rg2)));

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (frz || bubble)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_op && !dmem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Freeze masks branch and load-use decisions; EX is held, so they resurface once it drops.
  always_comb begin
    pc_en       = 1'b0;
    hold_1      = 1'b0;
    enb_1       = 1'b0;
    enb_2       = 1'b0;
    enb_3       = 1'b0;
    frz         = 1'b0;
    dmem_req    = 1'b0;
    timeout_err = 1'b0;
    bubble      = 1'b0;
    if (!reset) begin
      dmem_req    = mem_op && (state != ERR);
      frz         = (state == ERR) || (dmem_req && !dmem_ack);
      timeout_err = (state == ERR);
      enb_1       = 1'b1;
      enb_2       = 1'b1;
      enb_3       = 1'b1;
      if (!frz) begin
        pc_en = 1'b1;
        if (PCSel) begin
          enb_1 = 1'b0;
          enb_2 = 1'b0;
        end else if (load_use_hit) begin
          pc_en  = 1'b0;
          hold_1 = 1'b1;
          enb_2  = 1'b0;
          bubble = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, branch flush, dmem wait, timeout,
// reset abort and stall counter saturation (second instance with a 2-bit counter).
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] LD  = 5'b00000;
  localparam logic [4:0] ST  = 5'b01000;
  localparam logic [4:0] ALU = 5'b01100;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, opcode_rg2, rd_rg2, opcode_rg3;
  logic        rs1_used_id, rs2_used_id, PCSel, dmem_ack;
  logic        pc_en, hold_1, enb_1, enb_2, enb_3, frz, dmem_req, timeout_err;
  logic [15:0] stall_cnt;
  logic        s_pc_en, s_hold_1, s_enb_1, s_enb_2, s_enb_3, s_frz, s_dmem_req, s_timeout_err;
  logic [1:0]  s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .opcode_rg2(opcode_rg2),
    .rd_rg2(rd_rg2), .PCSel(PCSel), .opcode_rg3(opcode_rg3), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .hold_1(hold_1), .enb_1(enb_1), .enb_2(enb_2), .enb_3(enb_3),
    .frz(frz), .dmem_req(dmem_req), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_sat (
    .cpu_clk(cpu_clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .opcode_rg2(opcode_rg2),
    .rd_rg2(rd_rg2), .PCSel(PCSel), .opcode_rg3(opcode_rg3), .dmem_ack(dmem_ack),
    .pc_en(s_pc_en), .hold_1(s_hold_1), .enb_1(s_enb_1), .enb_2(s_enb_2), .enb_3(s_enb_3),
    .frz(s_frz), .dmem_req(s_dmem_req), .timeout_err(s_timeout_err), .stall_cnt(s_stall_cnt)
  );

  // {pc_en, hold_1, enb_1, enb_2, enb_3, frz, dmem_req, timeout_err}
  localparam logic [31:0] O_RESET  = 32'b00000000;
  localparam logic [31:0] O_IDLE   = 32'b10111000;
  localparam logic [31:0] O_LDUSE  = 32'b01101000;
  localparam logic [31:0] O_BRANCH = 32'b10001000;
  localparam logic [31:0] O_FRZ    = 32'b00111110;
  localparam logic [31:0] O_ACK    = 32'b10111010;
  localparam logic [31:0] O_ACKBR  = 32'b10001010;
  localparam logic [31:0] O_ERR    = 32'b00111101;

  function automatic logic [31:0] outs();
    return {24'd0, pc_en, hold_1, enb_1, enb_2, enb_3, frz, dmem_req, timeout_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_in();
    rs1_id = 5'd1; rs2_id = 5'd2; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    opcode_rg2 = ALU; rd_rg2 = 5'd3; PCSel = 1'b0; opcode_rg3 = ALU; dmem_ack = 1'b0;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    opcode_rg3 = LD; PCSel = 1'b1;
    tick(); tick();
    chk("reset_outs", outs(), O_RESET);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);

    idle_in();
    reset = 1'b0;
    #1;
    chk("idle_outs", outs(), O_IDLE);

    // Load x5 in EX, decode reads rs1=x5
    opcode_rg2 = LD; rd_rg2 = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
    #1; chk("lduse_rs1", outs(), O_LDUSE);
    tick();
    idle_in();
    #1; chk("lduse_clear", outs(), O_IDLE);
    chk("lduse_cnt", 32'(stall_cnt), 32'd1);

    opcode_rg2 = LD; rd_rg2 = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    #1; chk("lduse_rs2", outs(), O_LDUSE);
    tick();
    idle_in();
    #1; chk("lduse_cnt2", 32'(stall_cnt), 32'd2);

    opcode_rg2 = LD; rd_rg2 = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
    #1; chk("ld_x0", outs(), O_IDLE);
    rd_rg2 = 5'd7; rs1_id = 5'd7; rs2_id = 5'd7; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    #1; chk("ld_unused_src", outs(), O_IDLE);
    tick();
    chk("no_stall_cnt", 32'(stall_cnt), 32'd2);

    // Branch beats a simultaneous load-use
    idle_in();
    PCSel = 1'b1; opcode_rg2 = LD; rd_rg2 = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1;
    #1; chk("branch", outs(), O_BRANCH);
    tick();
    idle_in();
    #1; chk("branch_once", outs(), O_IDLE);
    chk("branch_cnt", 32'(stall_cnt), 32'd2);

    // Store in MEM, ack on the 4th cycle
    opcode_rg3 = ST;
    #1; chk("st_frz0", outs(), O_FRZ);
    tick(); chk("st_frz1", outs(), O_FRZ);
    tick(); chk("st_frz2", outs(), O_FRZ);
    tick();
    dmem_ack = 1'b1;
    #1; chk("st_ack", outs(), O_ACK);
    tick();
    idle_in();
    #1; chk("st_run", outs(), O_IDLE);
    chk("st_cnt", 32'(stall_cnt), 32'd5);
    chk("sat_cnt", 32'(s_stall_cnt), 32'd3);

    // Load in MEM; branch and load-use pending during the wait
    opcode_rg3 = LD; PCSel = 1'b1;
    opcode_rg2 = LD; rd_rg2 = 5'd4; rs2_id = 5'd4; rs2_used_id = 1'b1;
    #1; chk("ld_wait_frz0", outs(), O_FRZ);
    tick(); chk("ld_wait_frz1", outs(), O_FRZ);
    tick();
    dmem_ack = 1'b1;
    #1; chk("ld_ack_flush", outs(), O_ACKBR);
    tick();
    idle_in();
    #1; chk("ld_wait_cnt", 32'(stall_cnt), 32'd7);

    // Ack never comes: ERR after 4 wait cycles
    opcode_rg3 = ST;
    tick(); tick(); tick(); tick();
    chk("to_last_wait", outs(), O_FRZ);
    tick();
    chk("to_err", outs(), O_ERR);
    chk("to_cnt", 32'(stall_cnt), 32'd12);
    opcode_rg3 = ALU; dmem_ack = 1'b1;
    #1; chk("err_sticky", outs(), O_ERR);
    tick();
    chk("err_cnt", 32'(stall_cnt), 32'd13);
    chk("sat_hold", 32'(s_stall_cnt), 32'd3);

    // Reset out of ERR, and reset aborting a pending access
    reset = 1'b1;
    #1; chk("err_reset_outs", outs(), O_RESET);
    chk("err_reset_cnt", 32'(stall_cnt), 32'd0);
    chk("sat_reset", 32'(s_stall_cnt), 32'd0);
    tick();
    reset = 1'b0; dmem_ack = 1'b0;
    #1; chk("post_reset", outs(), O_IDLE);
    opcode_rg3 = ST;
    tick(); tick();
    chk("abort_frz", outs(), O_FRZ);
    reset = 1'b1;
    #1; chk("abort_reset", outs(), O_RESET);
    tick();
    reset = 1'b0; opcode_rg3 = ALU;
    #1; chk("abort_run", outs(), O_IDLE);
    opcode_rg3 = ST; dmem_ack = 1'b1;
    #1; chk("abort_fresh_ack", outs(), O_ACK);
    tick();
    chk("abort_cnt", 32'(stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
